// File: rtl/branch_resolve_queue_if.sv
// Predictor/EX handshake bundle for the branch resolve queue.
// slave is the queue side; master is the fetch/EX environment side.
interface branch_resolve_queue_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 8
);
    logic                    pushVld;
    logic                    pushRdy;
    logic [ADDR_WIDTH-1:0]   pushPC;
    logic [ADDR_WIDTH-1:0]   pushPdPC;
    logic                    pushBranch;
    logic                    pushReason;

    logic                    rsVld;
    logic [ADDR_WIDTH-1:0]   rsPC;
    logic [ADDR_WIDTH-1:0]   rsPCTar;
    logic [1:0]              rsType;
    logic                    rsBranch;
    logic                    rsLast;

    logic                    exVld;
    logic [ADDR_WIDTH-1:0]   exPC;
    logic [ADDR_WIDTH-1:0]   exPCTar;
    logic [1:0]              exType;
    logic                    exBranch;
    logic                    exWrong;
    logic                    flush;
    logic [ADDR_WIDTH-1:0]   redirPC;
    logic [$clog2(DEPTH):0]  count;

    modport master (
        output pushVld, pushPC, pushPdPC, pushBranch, pushReason,
        output rsVld, rsPC, rsPCTar, rsType, rsBranch, rsLast,
        input  pushRdy, exVld, exPC, exPCTar, exType, exBranch, exWrong,
        input  flush, redirPC, count
    );

    modport slave (
        input  pushVld, pushPC, pushPdPC, pushBranch, pushReason,
        input  rsVld, rsPC, rsPCTar, rsType, rsBranch, rsLast,
        output pushRdy, exVld, exPC, exPCTar, exType, exBranch, exWrong,
        output flush, redirPC, count
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of fetch-group predictions, checked against EX branch
// resolutions; produces registered predictor feedback, flush and redirect.
module branch_resolve_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    branch_resolve_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pd_mem [DEPTH];
    logic                  br_mem [DEPTH];
    logic                  reason_mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] occ;

    logic                  empty;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [ADDR_WIDTH-1:0] head_pd;
    logic                  head_br;
    logic                  head_reason;
    logic                  slot_upper;
    logic                  pred_taken;
    logic                  wrong;
    logic                  mispredict;
    logic                  pop;
    logic                  push_ok;
    logic [ADDR_WIDTH-1:0] fall_through;

    assign empty       = (occ == '0);
    assign head_pc     = pc_mem[head];
    assign head_pd     = pd_mem[head];
    assign head_br     = br_mem[head];
    assign head_reason = reason_mem[head];

    assign slot_upper  = (bus.rsPC != head_pc);
    assign pred_taken  = head_br && (head_reason == slot_upper);

    always_comb begin
        wrong = bus.rsBranch;
        if (!empty) begin
            // A taken lower prediction means the upper slot was never meant to run.
            if (head_br && !head_reason && slot_upper)
                wrong = 1'b1;
            else
                wrong = (bus.rsBranch != pred_taken) ||
                        (bus.rsBranch && (bus.rsPCTar != head_pd));
        end
    end

    assign mispredict   = bus.rsVld && wrong;
    assign pop          = bus.rsVld && bus.rsLast && !wrong && !empty;
    // A pop frees the head slot in the same edge, so a full queue still takes the push.
    assign push_ok      = bus.pushVld && !bus.flush && !mispredict &&
                          (bus.pushRdy || pop);
    assign fall_through = bus.rsPC + ADDR_WIDTH'(4);

    assign bus.pushRdy  = (occ != FULL);
    assign bus.count    = occ;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_mem[tail]     <= bus.pushPC;
            pd_mem[tail]     <= bus.pushPdPC;
            br_mem[tail]     <= bus.pushBranch;
            reason_mem[tail] <= bus.pushReason;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (mispredict) begin
            head <= tail;
            occ  <= '0;
        end else begin
            if (pop)     head <= head + 1'b1;
            if (push_ok) tail <= tail + 1'b1;
            case ({push_ok, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Registered EX feedback, flush and redirect
    always_ff @(posedge clk) begin
        if (rstn) begin
            bus.exVld    <= 1'b0;
            bus.exWrong  <= 1'b0;
            bus.exBranch <= 1'b0;
            bus.exPC     <= '0;
            bus.exPCTar  <= '0;
            bus.exType   <= '0;
            bus.flush    <= 1'b0;
            bus.redirPC  <= '0;
        end else begin
            bus.exVld   <= bus.rsVld;
            bus.exWrong <= mispredict;
            bus.flush   <= mispredict;
            if (bus.rsVld) begin
                bus.exPC     <= bus.rsPC;
                bus.exPCTar  <= bus.rsPCTar;
                bus.exType   <= bus.rsType;
                bus.exBranch <= bus.rsBranch;
            end
            if (mispredict)
                bus.redirPC <= bus.rsBranch ? bus.rsPCTar : fall_through;
        end
    end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Tracks every fetch-group prediction issued by the branch predictor, in order.
- Checks each prediction against the branch outcomes resolved in EX.
- Drives the EX-side feedback bus back into the predictor: ex valid, PC, target, type, branch taken, and mispredict.
- On a mispredict, drives the pipeline flush and the fetch redirect.
- Sits between the fetch stage (predictor output) and the execute stage (branch resolution).

Parameters:
- ADDR_WIDTH, 32, PC width.
- DEPTH, 8, queue entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous, active-high reset. Asserting 1 resets, despite the port name.
- pushVld  in  1  fetch group issued this cycle.
- pushRdy  out  1  queue not full.
- pushPC  in  ADDR_WIDTH  group base PC. The lower instruction is at pushPC, the upper at pushPC+4.
- pushPdPC  in  ADDR_WIDTH  predicted next PC.
- pushBranch  in  1  a taken branch was predicted.
- pushReason  in  1  0 = lower instruction caused the prediction, 1 = upper.
- rsVld  in  1  EX resolved one branch or jump instruction.
- rsPC  in  ADDR_WIDTH  PC of the resolved instruction.
- rsPCTar  in  ADDR_WIDTH  computed target.
- rsType  in  2  instruction type; passed through unchanged.
- rsBranch  in  1  actually taken.
- rsLast  in  1  last instruction of the head group; pop the head.
- exVld  out  1  feedback valid.
- exPC  out  ADDR_WIDTH  feedback PC.
- exPCTar  out  ADDR_WIDTH  feedback target.
- exType  out  2  feedback type.
- exBranch  out  1  feedback taken.
- exWrong  out  1  the prediction for this instruction was wrong.
- flush  out  1  flush the frontend.
- redirPC  out  ADDR_WIDTH  correct next PC, valid while flush=1.
- count  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer with head/tail pointers of clog2(DEPTH) bits (wrap naturally) and a count register. Entry fields: PC, PdPC, Branch, Reason.
- Reset: count=0, pointers=0, and every output 0: exVld, exWrong, exBranch, exPC, exPCTar, exType, flush, redirPC. pushRdy is 1 after reset. Reset asserted mid-operation discards all entries in the same edge.
- pushRdy = (count != DEPTH), combinational.
- A push is accepted when pushVld && pushRdy && !flush. A push while full is ignored, with no state change.
- Resolve, evaluated against the head entry H:
  - slot = (rsPC == H.PC) ? lower : upper.
  - predTaken = H.Branch && (H.Reason == slot).
  - wrong = (rsBranch != predTaken) || (rsBranch && rsPCTar != H.PdPC).
  - If H.Branch && H.Reason==0 and slot is upper: wrong=1 (the upper instruction should not have executed).
  - Resolve with an empty queue: wrong = rsBranch, and no pop.
- Outputs are registered, 1-cycle latency. The cycle after rsVld:
  - exVld=1.
  - exPC, exPCTar, exType, exBranch are copies of rsPC, rsPCTar, rsType, rsBranch.
  - exWrong=wrong.
  - Otherwise exVld and exWrong are 0 and the data holds its last value.
- Mispredict: in the same registered cycle as exWrong, flush=1 and redirPC = rsBranch ? rsPCTar : rsPC+4. flush is a 1-cycle pulse.
- On the edge that registers wrong=1, the queue clears to empty (count=0, head=tail). Any push in that cycle is dropped.
- Pop: rsVld && rsLast && !wrong && count>0 advances head.
- Push and pop in the same cycle: count unchanged; both succeed even when full, since pushRdy is evaluated before the pop.
- flush=1 blocks pushes for that cycle only.
- rsLast without rsVld is ignored.
- PC+4 arithmetic wraps modulo 2^ADDR_WIDTH.

Test Plan:
- Reset, then push 8 groups at PCs 0x1000, 0x1008, … → count=8, pushRdy=0; a 9th push is ignored and count stays 8.
- Head entry PC=0x1000, Branch=1, Reason=0, PdPC=0x2000; resolve rsPC=0x1000, rsBranch=1, rsPCTar=0x2000, rsLast=1 → next cycle exVld=1, exWrong=0, flush=0; count decrements by 1.
- Same head, resolve rsPCTar=0x3000 → exWrong=1, flush=1, redirPC=0x3000, count=0 next cycle; a push in that cycle is dropped.
- Head Branch=0; resolve rsPC=0x1004 (upper), rsBranch=0, rsLast=1 → exWrong=0; then resolve a taken upper branch on the next group → exWrong=1, redirPC=rsPCTar.
- Full queue with a simultaneous push and correct pop → count stays at DEPTH and the new entry lands at the wrapped tail; later it is resolved correctly at the head.
- Empty queue, rsVld with rsBranch=0 → exVld=1, exWrong=0. With rsBranch=1 and rsPC=0xFFFFFFFC → exWrong=1, redirPC=rsPCTar. A separate not-taken mispredict at 0xFFFFFFFC gives redirPC=0x00000000.
